prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/sap_pkg.sv | 18 +
 rtl/prog_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the program loader: state encoding, clear length and program RAM depth.
package sap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam int CLR_CYCLES = 2;
  localparam int MEM_DEPTH  = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

endpackage

// File: rtl/prog_loader.sv
// Program loader: clears the CPU, streams host bytes into program RAM, then releases the CPU.
// Optional feature macro LOADER_CHECKSUM_EN: final host byte is a mod-256 checksum instead of data.
module prog_loader
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              low_clr,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              low_ram_we,
  output logic              cpu_clr,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  byte_count
);

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        clr_cnt_q;
  logic              fin_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              accept;
  logic              do_write;
  logic              clr_entry;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
`endif

  assign accept    = in_valid && in_ready;
  assign clr_entry = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // fin_q marks the write cycle of the final byte: the loader stops accepting and enters RUN next.
  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    in_ready = 1'b0;
    cpu_clr  = 1'b1;
    run      = 1'b0;
    busy     = 1'b0;
    err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_cnt_q == 2'(CLR_CYCLES - 1)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = !fin_q;
        if (fin_q) begin
          state_d = ST_RUN;
        end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (in_last) begin
            state_d = (sum_q == in_data) ? ST_RUN : ST_ERR;
          end else if (byte_count == CNT_W'(MEM_DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            do_write = 1'b1;
          end
`else
          if (byte_count == CNT_W'(MEM_DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            do_write = 1'b1;
          end
`endif
        end
      end
      ST_RUN: begin
        cpu_clr = 1'b0;
        run     = 1'b1;
        if (start) state_d = ST_CLEAR;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) state_d = ST_CLEAR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write port is registered: an acceptance produces exactly one strobe cycle right after it.
  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      low_ram_we <= 1'b1;
      ram_addr   <= '0;
      ram_data   <= '0;
      wr_addr_q  <= '0;
      byte_count <= '0;
      clr_cnt_q  <= '0;
      fin_q      <= 1'b0;
      done       <= 1'b0;
    end else begin
      low_ram_we <= !do_write;
      fin_q      <= do_write && in_last;
      done       <= (state_d == ST_RUN) && (state_q != ST_RUN);
      if (do_write) begin
        ram_addr   <= wr_addr_q;
        ram_data   <= in_data;
        wr_addr_q  <= wr_addr_q + 1'b1;
        byte_count <= byte_count + 1'b1;
      end
      if (clr_entry) begin
        clr_cnt_q  <= '0;
        wr_addr_q  <= '0;
        byte_count <= '0;
      end else if (state_q == ST_CLEAR) begin
        clr_cnt_q  <= clr_cnt_q + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      sum_q <= '0;
    end else if (clr_entry) begin
      sum_q <= '0;
    end else if (do_write) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

endmodule
